fp_mult_sched: RTL and testbench

- Round-robin scheduler that shares one fp_mult instance (32-bit IEEE-754 single, free-running, non-stallable) between NREQ requesters.
- Accepts operand pairs over valid/ready and drives the multiplier's a/b inputs from registers.
- Tracks requester ids through a tag pipeline matched to the multiplier latency.
- Returns each product with its requester id.
- Sits between the lab's operand sources and fp_mult; fp_mult is instantiated outside this block.

---
 rtl/fp_mult_sched_pkg.sv | 13 +
 rtl/fp_mult_sched_rr_arbiter.sv | 43 ++++
 rtl/fp_mult_sched.sv | 107 ++++++++++
 tb/tb_fp_mult_sched.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/fp_mult_sched_pkg.sv
// Shared constants and helpers for the fp_mult scheduler.
package fp_mult_sched_pkg;

    localparam int unsigned FP_W = 32;
    localparam logic [FP_W-1:0] FP_ONE  = 32'h3F80_0000;
    localparam logic [FP_W-1:0] FP_ZERO = 32'h0000_0000;

    // Requester id width, never narrower than one bit.
    function automatic int unsigned id_w(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/fp_mult_sched_rr_arbiter.sv
// Round-robin arbiter: combinational one-hot grant, registered search pointer.
module rr_arbiter
    import fp_mult_sched_pkg::*;
#(
    parameter int unsigned N = 2,
    localparam int unsigned IW = id_w(N)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [N-1:0]  valid,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] idx,
    output logic          fire
);

    logic [IW-1:0] ptr;
    logic [IW-1:0] cand;

    // First valid requester at or above ptr, wrapping modulo N.
    always_comb begin
        grant = '0;
        idx   = '0;
        fire  = 1'b0;
        cand  = '0;
        for (int unsigned k = 0; k < N; k++) begin
            cand = IW'((32'(ptr) + k) % N);
            if (!fire && valid[cand]) begin
                fire        = 1'b1;
                idx         = cand;
                grant[cand] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr <= '0;
        end else if (fire) begin
            ptr <= (32'(idx) == N - 1) ? '0 : idx + IW'(1);
        end
    end

endmodule

// File: rtl/fp_mult_sched.sv
// Shares one free-running fp_mult between NREQ requesters with id tagging.
// Optional grant counters are built when FP_MULT_SCHED_STATS_EN is defined.
module fp_mult_sched
    import fp_mult_sched_pkg::*;
#(
    parameter int unsigned NREQ    = 2,
    parameter int unsigned MUL_LAT = 3,
    parameter int unsigned CNT_W   = 16,
    localparam int unsigned ID_W   = id_w(NREQ)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [NREQ*32-1:0]   req_a,
    input  logic [NREQ*32-1:0]   req_b,
    output logic [NREQ-1:0]      req_ready,
    output logic [31:0]          mul_a,
    output logic [31:0]          mul_b,
    input  logic [31:0]          mul_y,
    output logic                 rsp_valid,
    output logic [ID_W-1:0]      rsp_id,
    output logic [31:0]          rsp_y,
`ifdef FP_MULT_SCHED_STATS_EN
    output logic [NREQ*CNT_W-1:0] grant_cnt,
`endif
    output logic                 busy
);

    logic            fire;
    logic [ID_W-1:0] grant_idx;
    logic [FP_W-1:0] a_arr [NREQ];
    logic [FP_W-1:0] b_arr [NREQ];
    logic [MUL_LAT:0] tag_vld;
    logic [ID_W-1:0]  tag_id [MUL_LAT+1];

    rr_arbiter #(.N(NREQ)) u_arb (
        .clk   (clk),
        .rst   (rst),
        .valid (req_valid),
        .grant (req_ready),
        .idx   (grant_idx),
        .fire  (fire)
    );

    for (genvar i = 0; i < NREQ; i++) begin : g_unpack
        assign a_arr[i] = req_a[i*FP_W +: FP_W];
        assign b_arr[i] = req_b[i*FP_W +: FP_W];
    end

    // Operand registers feeding the multiplier; hold when nothing is granted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mul_a <= '0;
            mul_b <= '0;
        end else if (fire) begin
            mul_a <= a_arr[grant_idx];
            mul_b <= b_arr[grant_idx];
        end
    end

    // Tag pipe runs in lockstep with the multiplier; last stage aligns with mul_y.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tag_vld <= '0;
            for (int unsigned s = 0; s <= MUL_LAT; s++) tag_id[s] <= '0;
        end else begin
            tag_vld[0] <= fire;
            tag_id[0]  <= grant_idx;
            for (int unsigned s = 1; s <= MUL_LAT; s++) begin
                tag_vld[s] <= tag_vld[s-1];
                tag_id[s]  <= tag_id[s-1];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_valid <= 1'b0;
            rsp_id    <= '0;
            rsp_y     <= '0;
        end else begin
            rsp_valid <= tag_vld[MUL_LAT];
            if (tag_vld[MUL_LAT]) begin
                rsp_id <= tag_id[MUL_LAT];
                rsp_y  <= mul_y;
            end
        end
    end

    assign busy = fire | (|tag_vld);

`ifdef FP_MULT_SCHED_STATS_EN
    // Saturating per-requester grant counters.
    for (genvar i = 0; i < NREQ; i++) begin : g_cnt
        logic [CNT_W-1:0] cnt;
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                cnt <= '0;
            end else if (fire && grant_idx == ID_W'(i) && cnt != '1) begin
                cnt <= cnt + CNT_W'(1);
            end
        end
        assign grant_cnt[i*CNT_W +: CNT_W] = cnt;
    end
`endif

endmodule

// File: tb/tb_fp_mult_sched.sv
// Scoreboard bench for fp_mult_sched with a behavioural pipelined multiplier.
`timescale 1ns/1ps
module tb_fp_mult_sched;
    import fp_mult_sched_pkg::*;

    localparam int unsigned NREQ = 2;
    localparam int unsigned L    = 3;
    localparam int unsigned CW   = 2;

    typedef struct {
        int unsigned id;
        logic [31:0] y;
        int unsigned cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [NREQ-1:0]    req_valid = '0;
    logic [NREQ*32-1:0] req_a = '0;
    logic [NREQ*32-1:0] req_b = '0;
    logic [NREQ-1:0]    req_ready;
    logic [31:0] mul_a, mul_b, mul_y;
    logic        rsp_valid, busy;
    logic [0:0]  rsp_id;
    logic [31:0] rsp_y;
`ifdef FP_MULT_SCHED_STATS_EN
    logic [NREQ*CW-1:0] grant_cnt;
`endif

    exp_t        sb[$];
    int unsigned n_cmp = 0;
    int unsigned n_err = 0;
    int unsigned cyc = 0;
    int unsigned rsp_total = 0;
    int unsigned exp_ptr = 0;
    int unsigned gcnt [NREQ];
    logic [31:0] exp_y [NREQ];
    logic [31:0] mpipe [L];

    fp_mult_sched #(.NREQ(NREQ), .MUL_LAT(L), .CNT_W(CW)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_ready (req_ready),
        .mul_a     (mul_a),
        .mul_b     (mul_b),
        .mul_y     (mul_y),
        .rsp_valid (rsp_valid),
        .rsp_id    (rsp_id),
        .rsp_y     (rsp_y),
`ifdef FP_MULT_SCHED_STATS_EN
        .grant_cnt (grant_cnt),
`endif
        .busy      (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Normal-number fp32 multiply, truncating; vectors used are exact.
    function automatic logic [31:0] fmul(input logic [31:0] a, input logic [31:0] b);
        logic [47:0] m;
        logic [9:0]  e;
        if (a[30:23] == 8'd0 || b[30:23] == 8'd0) return {a[31] ^ b[31], 31'b0};
        m = 48'({1'b1, a[22:0]}) * 48'({1'b1, b[22:0]});
        e = 10'(a[30:23]) + 10'(b[30:23]) - 10'd127;
        if (m[47]) begin
            m = m >> 1;
            e = e + 10'd1;
        end
        return {a[31] ^ b[31], e[7:0], m[45:23]};
    endfunction

    // fp_mult stand-in: L register stages from mul_a/mul_b to mul_y.
    always @(posedge clk) begin
        mpipe[0] <= fmul(mul_a, mul_b);
        for (int k = 1; k < L; k++) mpipe[k] <= mpipe[k-1];
    end
    assign mul_y = mpipe[L-1];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every response must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (!rst && rsp_valid) begin
            rsp_total++;
            if (sb.size() == 0) begin
                check("unexpected_rsp", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("rsp_id", 32'(rsp_id), e.id);
                check("rsp_y", rsp_y, e.y);
                check("rsp_cycle", cyc, e.cyc);
            end
        end
    end

    // Drive one cycle of valids, check the grant, record the expected response.
    task automatic step(input logic [NREQ-1:0] v);
        logic [NREQ-1:0] g;
        int unsigned id;
        exp_t e;
        req_valid = v;
        #1;
        g  = '0;
        id = 0;
        for (int k = 0; k < NREQ; k++) begin
            int unsigned c;
            c = (exp_ptr + k) % NREQ;
            if (g == '0 && v[c]) begin
                g[c] = 1'b1;
                id = c;
            end
        end
        check("req_ready", 32'(req_ready), 32'(g));
        if (g != '0) begin
            e.id = id; e.y = exp_y[id]; e.cyc = cyc + L + 2;
            sb.push_back(e);
            exp_ptr = (id + 1) % NREQ;
            gcnt[id]++;
        end
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step('0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        sb.delete();
        exp_ptr = 0;
        for (int k = 0; k < NREQ; k++) gcnt[k] = 0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        int unsigned g0;
        int unsigned base;
        for (int k = 0; k < NREQ; k++) gcnt[k] = 0;
        @(negedge clk);
        @(negedge clk);
        #1;
        check("rst_ready", 32'(req_ready), 32'd0);
        check("rst_mul_a", mul_a, 32'd0);
        check("rst_mul_b", mul_b, 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rsp_id", 32'(rsp_id), 32'd0);
        check("rst_rsp_y", rsp_y, 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        idle(2);

        // Contention: 2.0*3.0 on req0, -1.5*2.0 on req1.
        req_a = {32'hBFC0_0000, 32'h4000_0000};
        req_b = {32'h4000_0000, 32'h4040_0000};
        exp_y[0] = 32'h40C0_0000;
        exp_y[1] = 32'hC040_0000;
        step(2'b11);
        step(2'b11);
        idle(8);

        // Single issue of 1.0*1.0 on req0.
        req_a[31:0] = FP_ONE;
        req_b[31:0] = FP_ONE;
        exp_y[0] = FP_ONE;
        step(2'b01);
        check("busy_inflight", 32'(busy), 32'd1);
        idle(7);
        check("busy_idle", 32'(busy), 32'd0);
        check("sb_drained_single", 32'(sb.size()), 32'd0);

        // Sustained: both valid for 20 cycles, grants must alternate.
        req_a[31:0] = 32'h4000_0000;
        req_b[31:0] = 32'h4040_0000;
        exp_y[0] = 32'h40C0_0000;
        g0 = gcnt[0];
        base = gcnt[1];
        for (int k = 0; k < 20; k++) step(2'b11);
        check("fair_req0", gcnt[0] - g0, 32'd10);
        check("fair_req1", gcnt[1] - base, 32'd10);
        idle(8);

        // Idle hold: 3.0*3.0 then 10 empty cycles.
        req_a[31:0] = 32'h4040_0000;
        req_b[31:0] = 32'h4040_0000;
        exp_y[0] = 32'h4110_0000;
        base = rsp_total;
        step(2'b01);
        idle(10);
        check("hold_mul_a", mul_a, 32'h4040_0000);
        check("hold_mul_b", mul_b, 32'h4040_0000);
        check("hold_rsp_count", rsp_total - base, 32'd1);
        step(2'b11);
        idle(8);

        // Reset two cycles after a grant discards the in-flight result.
        step(2'b01);
        idle(2);
        rst = 1'b1;
        #1;
        check("midrst_mul_a", mul_a, 32'd0);
        check("midrst_rsp_y", rsp_y, 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        do_reset();
        base = rsp_total;
        idle(8);
        check("midrst_no_rsp", rsp_total - base, 32'd0);
        step(2'b11);
        idle(8);

        // Five grants to req0 after a fresh reset.
        do_reset();
        for (int k = 0; k < 5; k++) step(2'b01);
        idle(8);
`ifdef FP_MULT_SCHED_STATS_EN
        check("grant_cnt0", 32'(grant_cnt[CW-1:0]), 32'd3);
        check("grant_cnt1", 32'(grant_cnt[2*CW-1:CW]), 32'd0);
`endif

        for (int k = 0; k < 20 && sb.size() != 0; k++) @(negedge clk);
        check("sb_empty_end", 32'(sb.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule
